// File: rtl/arb_burst_mux_pkg.sv
// Shared arbiter-path definitions: requester count, source index width, burst FSM states.
// Reused by the arbiter, the requester-side blocks and arb_burst_mux.
package arb_pkg;
    localparam int NREQ  = 4;
    localparam int SRC_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_state_t;
endpackage

// File: rtl/arb_burst_mux_if.sv
// Bus bundle between requesters/arbiter (master side) and arb_burst_mux (slave side).
// All handshakes are valid/ready: a beat transfers on a rising clk edge where both are high.
interface arb_burst_mux_if #(
    parameter int DW        = 32,
    parameter int MAX_BEATS = 16
);
    import arb_pkg::*;
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    logic [NREQ-1:0]    gnt_in;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic               out_last;
    logic [SRC_W-1:0]   out_src;
    logic               out_ready;
    logic               burst_done;
    logic               busy;
    logic               err_timeout;
    burst_state_t       dbg_state;
    logic [CNT_W-1:0]   dbg_beat_cnt;

    modport master (
        output gnt_in, req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, out_src,
               burst_done, busy, err_timeout, dbg_state, dbg_beat_cnt
    );

    modport slave (
        input  gnt_in, req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, out_src,
               burst_done, busy, err_timeout, dbg_state, dbg_beat_cnt
    );
endinterface

// File: rtl/arb_burst_mux_onehot.sv
// onehot_to_idx: index of the lowest set bit of a requester vector; 0 for an all-zero input.
module onehot_to_idx
    import arb_pkg::*;
(
    input  logic [NREQ-1:0]  onehot_i,
    output logic [SRC_W-1:0] idx_o
);
    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx_o = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (onehot_i[i]) idx_o = SRC_W'(i);
        end
    end
endmodule

// File: rtl/arb_burst_mux.sv
// Locks onto the granted requester for a whole burst and muxes its beats into one output register.
// Optional burst beat limit with sticky err_timeout when ARB_BURST_TIMEOUT_EN is defined.
module arb_burst_mux
    import arb_pkg::*;
#(
    parameter int DW        = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic            clk,
    input  logic            rst,
    arb_burst_mux_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    burst_state_t     state_q, state_d;
    logic [SRC_W-1:0] src_q, src_d, gnt_idx;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [NREQ-1:0]  req_ready_d;
    logic             out_valid_q, out_last_q, burst_done_q;
    logic [DW-1:0]    out_data_q;
    logic [SRC_W-1:0] out_src_q;
    logic             slot_free, beat_hs, beat_last, limit_hit, end_burst;
    logic [DW-1:0]    sel_data;

    onehot_to_idx u_gnt_idx (
        .onehot_i (bus.gnt_in),
        .idx_o    (gnt_idx)
    );

    // Output slot can take a beat when empty or being drained in this same cycle.
    assign slot_free = !out_valid_q || bus.out_ready;
    assign sel_data  = bus.req_data[src_q*DW +: DW];
    assign beat_hs   = (state_q == BURST) && slot_free && bus.req_valid[src_q];
    assign beat_last = bus.req_last[src_q] || limit_hit;
    assign end_burst = beat_hs && beat_last;

`ifdef ARB_BURST_TIMEOUT_EN
    logic err_q;

    assign limit_hit = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (beat_hs && limit_hit && !bus.req_last[src_q]) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_timeout = err_q;
`else
    assign limit_hit       = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        beat_cnt_d  = beat_cnt_q;
        req_ready_d = '0;
        case (state_q)
            IDLE: begin
                if (bus.gnt_in != '0) begin
                    state_d    = BURST;
                    src_d      = gnt_idx;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                req_ready_d[src_q] = slot_free;
                if (beat_hs) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_src_q    <= '0;
            burst_done_q <= 1'b0;
        end else begin
            burst_done_q <= end_burst;
            if (beat_hs) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sel_data;
                out_last_q  <= beat_last;
                out_src_q   <= src_q;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready    = req_ready_d;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_last     = out_last_q;
    assign bus.out_src      = out_src_q;
    assign bus.burst_done   = burst_done_q;
    assign bus.busy         = (state_q == BURST);
    assign bus.dbg_state    = state_q;
    assign bus.dbg_beat_cnt = beat_cnt_q;
endmodule

// File: doc/arb_burst_mux.md
Name: arb_burst_mux

Overview:
- Downstream consumer of the 4-requester round-robin arbiter in the shared-resource path.
- Samples the arbiter's one-hot grant and locks onto that requester for one whole burst.
- Muxes the granted requester's payload into a single registered valid/ready output stage.
- Pulses burst_done when the burst ends so the arbiter's rotation and the requester bookkeeping advance cleanly.

Parameters:
- DW, 32, payload width per requester.
- MAX_BEATS, 16, burst beat limit; used only when the timeout feature is compiled in.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- gnt_in  input  4  one-hot grant from the arbiter.
- req_valid  input  4  per-requester beat valid.
- req_data  input  4*DW  packed payloads; requester i occupies bits [i*DW +: DW].
- req_last  input  4  per-requester last-beat flag.
- req_ready  output  4  per-requester beat accept.
- out_valid  output  1  output beat valid.
- out_data  output  DW  output payload.
- out_last  output  1  output last-beat flag.
- out_src  output  2  index of the requester that owns the output beat.
- out_ready  input  1  downstream accept.
- burst_done  output  1  one-cycle pulse marking burst completion.
- busy  output  1  high while in BURST.
- err_timeout  output  1  sticky timeout error flag.

Behaviour:
- Reset (asynchronous) values:
  - state = IDLE.
  - out_valid, out_data, out_last, out_src, burst_done, err_timeout = 0.
  - beat_cnt = 0.
  - req_ready = 0 (combinational, 0 whenever in IDLE).
- Reset mid-burst aborts the burst immediately. No burst_done is generated.
- State IDLE:
  - req_ready = 0.
  - If gnt_in != 0, latch src_q = index of the lowest set bit of gnt_in, clear beat_cnt, and go to BURST next cycle.
  - A non-one-hot gnt_in resolves to its lowest index; this is not an error.
  - gnt_in == 0 stays in IDLE.
- State BURST:
  - gnt_in is ignored; changes in gnt_in do not affect the burst.
  - slot_free = !out_valid || out_ready.
  - req_ready[src_q] = slot_free; all other req_ready bits = 0.
  - On handshake (req_valid[src_q] && req_ready[src_q]), next cycle:
    - out_data = req_data[src_q].
    - out_last = req_last[src_q].
    - out_src = src_q.
    - out_valid = 1.
    - beat_cnt increments.
  - If the accepted beat has last = 1: go to IDLE, and burst_done = 1 for exactly the next cycle.
- Output register:
  - out_valid clears when out_ready && !new_load.
  - A simultaneous drain and load keeps out_valid = 1 with the new beat, giving full throughput with no bubble.
  - out_* hold stable while out_valid && !out_ready.
- Latency and throughput:
  - Input handshake to out_valid: 1 cycle.
  - Grant sample to first possible req_ready: 1 cycle.
  - Minimum 1 idle cycle between bursts.
- busy = (state == BURST).
- A single-beat burst (first beat with last = 1) is legal: BURST lasts one handshake.

Optional Feature:
- Macro: ARB_BURST_TIMEOUT_EN.
- Defined:
  - Counter width is $clog2(MAX_BEATS+1).
  - If the MAX_BEATS-th accepted beat has last = 0, that beat is forced out with out_last = 1.
  - The block returns to IDLE and burst_done pulses as normal.
  - err_timeout sets to 1 and stays set until rst.
- Undefined:
  - Bursts are unbounded and no counter limit is checked.
  - err_timeout is tied to 0. The port always exists.

Decomposition:
- Shared package arb_pkg:
  - NREQ = 4, SRC_W = 2.
  - typedef enum logic {IDLE, BURST} burst_state_t.
  - Reused by the arbiter and the requester-side blocks.
- One sub-module: onehot_to_idx. Combinational 4-bit input to 2-bit index, lowest set bit wins, output 0 for zero input. It is instantiated once for gnt_in.

Test Plan:
1. Reset: assert rst mid-burst (src 2, 3 beats in) -> all outputs 0, busy = 0 in the same cycle; after release with gnt_in = 0 -> stays IDLE.
2. Basic burst: gnt_in = 4'b0010, req1 sends 4 beats with last on beat 4, out_ready = 1 -> out_data matches with 1-cycle latency, out_src = 1, burst_done pulses once, busy drops the cycle after beat 4.
3. Backpressure: out_ready = 0 for 3 cycles during a burst -> req_ready[src] = 0 while the output register is full; out_data stays stable; no beat is lost or duplicated.
4. Grant changes mid-burst: gnt_in switches 0001 -> 1000 during src-0's burst -> src-0 finishes; req_ready[3] = 0 until src-0's last beat is accepted; then src-3 is locked.
5. Non-one-hot / single beat: gnt_in = 4'b1100 with req2 beat last = 1 -> out_src = 2, single-beat burst, burst_done pulse, back in IDLE next cycle.
6. Timeout (ARB_BURST_TIMEOUT_EN, MAX_BEATS = 16): 20 beats with no last -> beat 16 carries out_last = 1, err_timeout = 1 and stays set; beats 17+ are not accepted until a new grant.
